// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network readout blocks.
package snn_pkg;

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam int unsigned CntWDefault   = 4;
  localparam int unsigned WindowDefault = 15;

  // Increment val by inc, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_add(input logic [31:0] val, input logic inc,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (inc && (val != max_val)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result bundle of the spike rate decoder: latched rates, argmax and valid/ready handshake.
interface spike_rate_decoder_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 4
);
  localparam int unsigned WinW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*CNT_W-1:0] rate_out;
  logic [WinW-1:0]         winner;
  logic                    winner_valid;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output rate_out, winner, winner_valid, out_valid,
    input  out_ready
  );

  modport slave (
    input  rate_out, winner, winner_valid, out_valid,
    output out_ready
  );
endinterface

// File: rtl/sat_counter.sv
// CNT_W-bit up counter with synchronous clear that holds at all-ones.
module sat_counter
  import snn_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else       cnt_d = CNT_W'(sat_add(32'(cnt_q), inc_i, CNT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/spike_rate_decoder.sv
// Per-channel spike rate decoder over a fixed window, with argmax readout.
// Define DECODER_WINNER_EN to build the argmax comparator; otherwise winner/winner_valid are 0.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned WINDOW = WindowDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    spike_in,
  output logic                 overrun,
  input  logic                 clr_overrun,
  spike_rate_decoder_if.master res
);
  localparam int unsigned WinW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned WcntW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  state_e                  state_q, state_d;
  logic [WcntW-1:0]        wcnt_q, wcnt_d;
  logic [NUM_CH*CNT_W-1:0] rate_q, rate_d;
  logic [WinW-1:0]         winner_q, winner_d;
  logic                    wvalid_q, wvalid_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic [CNT_W-1:0]        ch_cnt [NUM_CH];

  logic counting, win_end;
  assign counting = (state_q == StCount) && en;
  assign win_end  = counting && (wcnt_q == WcntW'(WINDOW - 1));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (counting & spike_in[g]),
      .clr_i (!counting || win_end),
      .cnt_o (ch_cnt[g])
    );
  end

  always_comb begin
    state_d     = en ? StCount : StIdle;
    wcnt_d      = (counting && !win_end) ? wcnt_q + WcntW'(1) : '0;
    rate_d      = rate_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (out_valid_q && res.out_ready) out_valid_d = 1'b0;
    if (clr_overrun)                  overrun_d   = 1'b0;
    if (win_end) begin
      // The closing cycle's spike is folded straight into the latched rate.
      for (int i = 0; i < NUM_CH; i++) begin
        rate_d[i*CNT_W +: CNT_W] = CNT_W'(sat_add(32'(ch_cnt[i]), spike_in[i], CNT_W));
      end
      out_valid_d = 1'b1;
      if (out_valid_q && !res.out_ready) overrun_d = 1'b1;
    end
  end

`ifdef DECODER_WINNER_EN
  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    logic [CNT_W-1:0] best;
    best     = '0;
    winner_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rate_d[i*CNT_W +: CNT_W] > best) begin
        best     = rate_d[i*CNT_W +: CNT_W];
        winner_d = WinW'(i);
      end
    end
    wvalid_d = (best != '0);
  end
`else
  assign winner_d = '0;
  assign wvalid_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      rate_q      <= '0;
      winner_q    <= '0;
      wvalid_q    <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rate_q      <= rate_d;
      winner_q    <= winner_d;
      wvalid_q    <= wvalid_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res.rate_out     = rate_q;
  assign res.winner       = winner_q;
  assign res.winner_valid = wvalid_q;
  assign res.out_valid    = out_valid_q;
  assign overrun          = overrun_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: one DUT with a 15-cycle window, one with 20 cycles.
module tb_spike_rate_decoder;
`ifdef DECODER_WINNER_EN
  localparam bit WinEn = 1'b1;
`else
  localparam bit WinEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic [1:0] spike_a = '0, spike_b = '0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic       overrun_a, overrun_b;
  int         checks = 0;
  int         failures = 0;

  spike_rate_decoder_if #(.NUM_CH(2), .CNT_W(4)) ifa ();
  spike_rate_decoder_if #(.NUM_CH(2), .CNT_W(4)) ifb ();

  spike_rate_decoder #(.NUM_CH(2), .CNT_W(4), .WINDOW(15)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .en          (en_a),
    .spike_in    (spike_a),
    .overrun     (overrun_a),
    .clr_overrun (clr_a),
    .res         (ifa)
  );

  spike_rate_decoder #(.NUM_CH(2), .CNT_W(4), .WINDOW(20)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .en          (en_b),
    .spike_in    (spike_b),
    .overrun     (overrun_b),
    .clr_overrun (clr_b),
    .res         (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input int n, input int p0, input int p1);
    for (int j = 0; j < n; j++) begin
      spike_a[0] = (p0 != 0) && (j % p0 == 0);
      spike_a[1] = (p1 != 0) && (j % p1 == 0);
      tick();
    end
    spike_a = '0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (ifa.rate_out !== 8'h00 || ifa.out_valid !== 1'b0 || overrun_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a rate=%h valid=%b ovr=%b expected 00/0/0",
               ifa.rate_out, ifa.out_valid, overrun_a);
    end
    checks++;
    if (ifa.winner !== 1'b0 || ifa.winner_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_winner got %b/%b expected 0/0", ifa.winner, ifa.winner_valid);
    end
    checks++;
    if (ifb.rate_out !== 8'h00 || ifb.out_valid !== 1'b0 || overrun_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b rate=%h valid=%b ovr=%b expected 00/0/0",
               ifb.rate_out, ifb.out_valid, overrun_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation;
    en_b = 1'b1;
    tick();
    spike_b = 2'b11;
    for (int j = 0; j < 20; j++) tick();
    spike_b = 2'b00;
    checks++;
    if (ifb.rate_out !== 8'hFF || ifb.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_rate got %h/%b expected ff/1", ifb.rate_out, ifb.out_valid);
    end
    checks++;
    if (ifb.winner !== 1'b0 || ifb.winner_valid !== WinEn) begin
      failures++;
      $display("FAIL sat_tie_winner got %b/%b expected 0/%b",
               ifb.winner, ifb.winner_valid, WinEn);
    end
    for (int j = 0; j < 20; j++) tick();
    checks++;
    if (ifb.rate_out !== 8'h00 || ifb.winner_valid !== 1'b0 || ifb.winner !== 1'b0) begin
      failures++;
      $display("FAIL silent_window got %h/%b/%b expected 00/0/0",
               ifb.rate_out, ifb.winner, ifb.winner_valid);
    end
    checks++;
    if (overrun_b !== 1'b1) begin
      failures++;
      $display("FAIL sat_overrun got %b expected 1", overrun_b);
    end
    en_b = 1'b0;
  endtask

  task automatic test_rate_count;
    en_a = 1'b1;
    tick();
    run_a(14, 3, 1);
    checks++;
    if (ifa.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_result got valid=%b expected 0", ifa.out_valid);
    end
    spike_a = 2'b10;
    tick();
    spike_a = 2'b00;
    checks++;
    if (ifa.rate_out !== 8'hF5 || ifa.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rate_count got %h/%b expected f5/1", ifa.rate_out, ifa.out_valid);
    end
    checks++;
    if (ifa.winner !== WinEn || ifa.winner_valid !== WinEn) begin
      failures++;
      $display("FAIL rate_winner got %b/%b expected %b/%b",
               ifa.winner, ifa.winner_valid, WinEn, WinEn);
    end
  endtask

  task automatic test_reset_mid;
    run_a(7, 1, 1);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ifa.rate_out !== 8'h00 || ifa.out_valid !== 1'b0 || ifa.winner_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got %h/%b/%b expected 00/0/0",
               ifa.rate_out, ifa.out_valid, ifa.winner_valid);
    end
    rst = 1'b0;
    tick();
    run_a(14, 3, 1);
    checks++;
    if (ifa.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_latency got valid=%b expected 0", ifa.out_valid);
    end
    spike_a = 2'b10;
    tick();
    spike_a = 2'b00;
    checks++;
    if (ifa.rate_out !== 8'hF5 || ifa.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_rate got %h/%b expected f5/1", ifa.rate_out, ifa.out_valid);
    end
  endtask

  task automatic test_accept_silent;
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    checks++;
    if (ifa.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL accept_drop got valid=%b expected 0", ifa.out_valid);
    end
    run_a(14, 0, 0);
    checks++;
    if (ifa.rate_out !== 8'h00 || ifa.out_valid !== 1'b1 || ifa.winner_valid !== 1'b0 ||
        overrun_a !== 1'b0) begin
      failures++;
      $display("FAIL silent_a got %h/%b/%b/%b expected 00/1/0/0",
               ifa.rate_out, ifa.out_valid, ifa.winner_valid, overrun_a);
    end
  endtask

  task automatic test_overrun;
    run_a(15, 1, 0);
    checks++;
    if (ifa.rate_out !== 8'h0F || overrun_a !== 1'b1) begin
      failures++;
      $display("FAIL overwrite got %h/%b expected 0f/1", ifa.rate_out, overrun_a);
    end
    checks++;
    if (ifa.winner !== 1'b0 || ifa.winner_valid !== WinEn) begin
      failures++;
      $display("FAIL overwrite_winner got %b/%b expected 0/%b",
               ifa.winner, ifa.winner_valid, WinEn);
    end
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 15; j++) begin
      spike_a       = 2'b10;
      clr_a         = (j == 0);
      ifa.out_ready = (j == 14);
      tick();
      if (j == 0) begin
        checks++;
        if (overrun_a !== 1'b0) begin
          failures++;
          $display("FAIL clr_overrun got %b expected 0", overrun_a);
        end
      end
    end
    spike_a = 2'b00;
    clr_a = 1'b0;
    ifa.out_ready = 1'b0;
    checks++;
    if (ifa.out_valid !== 1'b1 || overrun_a !== 1'b0 || ifa.rate_out !== 8'hF0) begin
      failures++;
      $display("FAIL accept_and_load got %b/%b/%h expected 1/0/f0",
               ifa.out_valid, overrun_a, ifa.rate_out);
    end
    checks++;
    if (ifa.winner !== WinEn) begin
      failures++;
      $display("FAIL b2b_winner got %b expected %b", ifa.winner, WinEn);
    end
    for (int j = 0; j < 15; j++) begin
      spike_a[0] = (j % 3 == 0);
      clr_a      = (j == 14);
      tick();
    end
    spike_a = 2'b00;
    clr_a = 1'b0;
    checks++;
    if (overrun_a !== 1'b1 || ifa.rate_out !== 8'h05) begin
      failures++;
      $display("FAIL set_wins got %b/%h expected 1/05", overrun_a, ifa.rate_out);
    end
  endtask

  task automatic test_en_drop;
    for (int j = 0; j < 9; j++) begin
      spike_a[0] = (j < 6);
      tick();
    end
    en_a = 1'b0;
    spike_a = 2'b00;
    for (int j = 0; j < 4; j++) tick();
    checks++;
    if (ifa.rate_out !== 8'h05 || ifa.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL en_drop_hold got %h/%b expected 05/1", ifa.rate_out, ifa.out_valid);
    end
    en_a = 1'b1;
    tick();
    run_a(14, 0, 2);
    checks++;
    if (ifa.rate_out !== 8'h05) begin
      failures++;
      $display("FAIL en_restart_early got %h expected 05", ifa.rate_out);
    end
    spike_a = 2'b10;
    tick();
    spike_a = 2'b00;
    checks++;
    if (ifa.rate_out !== 8'h80 || ifa.winner !== WinEn || ifa.winner_valid !== WinEn) begin
      failures++;
      $display("FAIL en_restart got %h/%b/%b expected 80/%b/%b",
               ifa.rate_out, ifa.winner, ifa.winner_valid, WinEn, WinEn);
    end
  endtask

  initial begin
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    test_reset();
    @(negedge clk);
    test_saturation();
    test_rate_count();
    test_reset_mid();
    test_accept_silent();
    test_overrun();
    test_back_to_back();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
